// File: rtl/tone_pkg.sv
// ============================================================================
// Module      : tone_pkg
// Description : Shared types, direction codes and priority-encode helper
//               for the tone detection blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tone_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE    = 2'd0;
    localparam state_t c_QUALIFY = 2'd1;
    localparam state_t c_HOLD    = 2'd2;
    localparam state_t c_REARM   = 2'd3;

    // {stop, code} for the default 2-bit code width
    localparam logic [2:0] c_STOP     = 3'b100;
    localparam logic [1:0] c_STRAIGHT = 2'd0;
    localparam logic [1:0] c_LEFT     = 2'd1;
    localparam logic [1:0] c_RIGHT    = 2'd2;
    localparam logic [1:0] c_BACK     = 2'd3;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic int unsigned lowest_set_idx(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tone_priority_enc.sv
// ============================================================================
// Module      : tone_priority_enc
// Description : Combinational lowest-index-wins encoder with any-valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_priority_enc
    import tone_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIR_W  = 2
) (
    input  logic [NUM_CH-1:0] i_tone,
    output logic [DIR_W-1:0]  o_code,
    output logic              o_valid
);

    logic [31:0] w_vec;

    always_comb begin
        w_vec               = '0;
        w_vec[NUM_CH-1:0]   = i_tone;
    end

    assign o_code  = DIR_W'(lowest_set_idx(w_vec));
    assign o_valid = |i_tone;

endmodule

`default_nettype wire

// File: rtl/tone_direction_decoder.sv
// ============================================================================
// Module      : tone_direction_decoder
// Description : Qualifies a sustained tone, presents its direction code for a
//               fixed hold window, then returns to STOP with optional re-arm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_direction_decoder
    import tone_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIR_W       = 2,
    parameter int CNT_W       = 32,
    parameter int QUAL_CYCLES = 12_500_000,
    parameter int HOLD_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 0,
    parameter bit REARM_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] tone_in,
    output logic [DIR_W:0]    td_dir,
    output logic              det_pulse,
    output logic [DIR_W-1:0]  det_ch
);

    localparam logic [DIR_W:0]   c_STOP_CODE = {1'b1, {DIR_W{1'b0}}};
    localparam logic [CNT_W-1:0] c_QUAL_LAST = CNT_W'(QUAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_MAX   = CNT_W'(GAP_CYCLES);

    logic [DIR_W-1:0] w_enc_code;
    logic             w_any;

    state_t           state_q,     state_d;
    logic [DIR_W-1:0] cand_q,      cand_d;
    logic [CNT_W-1:0] qual_cnt_q,  qual_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q,   gap_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [DIR_W:0]   td_dir_q,    td_dir_d;
    logic             det_pulse_q, det_pulse_d;
    logic [DIR_W-1:0] det_ch_q,    det_ch_d;

    tone_priority_enc #(
        .NUM_CH (NUM_CH),
        .DIR_W  (DIR_W)
    ) u_enc (
        .i_tone  (tone_in),
        .o_code  (w_enc_code),
        .o_valid (w_any)
    );

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        qual_cnt_d  = qual_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        td_dir_d    = td_dir_q;
        det_pulse_d = 1'b0;
        det_ch_d    = det_ch_q;

        case (state_q)
            c_IDLE: begin
                qual_cnt_d = '0;
                gap_cnt_d  = '0;
                td_dir_d   = c_STOP_CODE;
                if (en && w_any) begin
                    cand_d  = w_enc_code;
                    state_d = c_QUALIFY;
                end
            end

            c_QUALIFY: begin
                if (!en) begin
                    state_d = c_IDLE;
                end else if (tone_in[cand_q]) begin
                    gap_cnt_d = '0;
                    if (qual_cnt_q == c_QUAL_LAST) begin
                        state_d     = c_HOLD;
                        hold_cnt_d  = '0;
                        td_dir_d    = {1'b0, cand_q};
                        det_ch_d    = cand_q;
                        det_pulse_d = 1'b1;
                    end else begin
                        qual_cnt_d = qual_cnt_q + 1'b1;
                    end
                end else if (gap_cnt_q == c_GAP_MAX) begin
                    // One more low cycle would exceed the dropout tolerance
                    state_d = c_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            c_HOLD: begin
                if (hold_cnt_q == c_HOLD_LAST) begin
                    td_dir_d = c_STOP_CODE;
                    state_d  = REARM_EN ? c_REARM : c_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            c_REARM: begin
                td_dir_d = c_STOP_CODE;
                if (tone_in == '0) state_d = c_IDLE;
            end

            default: begin
                state_d  = c_IDLE;
                td_dir_d = c_STOP_CODE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= c_IDLE;
            cand_q      <= '0;
            qual_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            td_dir_q    <= c_STOP_CODE;
            det_pulse_q <= 1'b0;
            det_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            qual_cnt_q  <= qual_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            td_dir_q    <= td_dir_d;
            det_pulse_q <= det_pulse_d;
            det_ch_q    <= det_ch_d;
        end
    end

    assign td_dir    = td_dir_q;
    assign det_pulse = det_pulse_q;
    assign det_ch    = det_ch_q;

endmodule

`default_nettype wire

// File: tb/tb_tone_direction_decoder.sv
// ============================================================================
// Module      : tb_tone_direction_decoder
// Description : Directed self-checking bench for tone_direction_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tone_direction_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] tone_in;
    logic [2:0] td_dir;
    logic       det_pulse;
    logic [1:0] det_ch;
    logic [2:0] td_dir_nr;
    logic       det_pulse_nr;
    logic [1:0] det_ch_nr;

    int passed;
    int total;

    localparam logic [2:0] c_STOP = 3'b100;

    tone_direction_decoder #(
        .NUM_CH(4), .DIR_W(2), .CNT_W(32),
        .QUAL_CYCLES(4), .HOLD_CYCLES(6), .GAP_CYCLES(1), .REARM_EN(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tone_in(tone_in),
        .td_dir(td_dir), .det_pulse(det_pulse), .det_ch(det_ch)
    );

    tone_direction_decoder #(
        .NUM_CH(4), .DIR_W(2), .CNT_W(32),
        .QUAL_CYCLES(4), .HOLD_CYCLES(6), .GAP_CYCLES(1), .REARM_EN(1'b0)
    ) dut_nr (
        .clk(clk), .rst_n(rst_n), .en(en), .tone_in(tone_in),
        .td_dir(td_dir_nr), .det_pulse(det_pulse_nr), .det_ch(det_ch_nr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    // After this the current cycle is cycle 0 with the design in IDLE.
    task automatic reset_dut();
        rst_n   = 1'b0;
        en      = 1'b1;
        tone_in = 4'b0000;
        step();
        rst_n   = 1'b1;
    endtask

    initial begin
        logic [2:0] exp_dir;
        logic       exp_pulse;
        passed  = 0;
        total   = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        tone_in = 4'b0000;
        step();

        // 1: channel 1 held 20 cycles, single detection then re-arm lockout
        reset_dut();
        chk("s1_reset_dir",   0, 32'(td_dir),    32'(c_STOP));
        chk("s1_reset_pulse", 0, 32'(det_pulse), 32'(1'b0));
        chk("s1_reset_ch",    0, 32'(det_ch),    32'(2'd0));
        for (int c = 0; c < 25; c++) begin
            exp_dir   = (c >= 5 && c <= 10) ? 3'b001 : c_STOP;
            exp_pulse = (c == 5);
            chk("s1_dir",   c, 32'(td_dir),    32'(exp_dir));
            chk("s1_pulse", c, 32'(det_pulse), 32'(exp_pulse));
            if (c >= 5) chk("s1_ch", c, 32'(det_ch), 32'(2'd1));
            tone_in = (c < 20) ? 4'b0010 : 4'b0000;
            step();
        end

        // 2a: one-cycle dropout tolerated, adds a cycle of latency
        reset_dut();
        for (int c = 0; c < 13; c++) begin
            exp_dir   = (c >= 6 && c <= 11) ? 3'b000 : c_STOP;
            exp_pulse = (c == 6);
            chk("s2a_dir",   c, 32'(td_dir),    32'(exp_dir));
            chk("s2a_pulse", c, 32'(det_pulse), 32'(exp_pulse));
            tone_in = (c == 2) ? 4'b0000 : 4'b0001;
            step();
        end

        // 2b: two-cycle dropout aborts; tone returning in cycle 4 starts afresh
        reset_dut();
        for (int c = 0; c < 16; c++) begin
            exp_dir   = (c >= 9 && c <= 14) ? 3'b000 : c_STOP;
            exp_pulse = (c == 9);
            chk("s2b_dir",   c, 32'(td_dir),    32'(exp_dir));
            chk("s2b_pulse", c, 32'(det_pulse), 32'(exp_pulse));
            tone_in = (c == 2 || c == 3) ? 4'b0000 : 4'b0001;
            step();
        end

        // 3: simultaneous channels 2 and 3, lowest wins; channel 3 drops
        reset_dut();
        for (int c = 0; c < 12; c++) begin
            exp_dir   = (c >= 5 && c <= 10) ? 3'b010 : c_STOP;
            exp_pulse = (c == 5);
            chk("s3_dir",   c, 32'(td_dir),    32'(exp_dir));
            chk("s3_pulse", c, 32'(det_pulse), 32'(exp_pulse));
            if (c >= 5) chk("s3_ch", c, 32'(det_ch), 32'(2'd2));
            tone_in = (c < 2) ? 4'b1100 : 4'b0100;
            step();
        end

        // 4: reset pulse in cycle 7 of a hold, then full-latency requalify
        reset_dut();
        for (int c = 0; c < 20; c++) begin
            exp_dir   = ((c >= 5 && c <= 7) || (c >= 13 && c <= 18)) ? 3'b001 : c_STOP;
            exp_pulse = (c == 5 || c == 13);
            chk("s4_dir",   c, 32'(td_dir),    32'(exp_dir));
            chk("s4_pulse", c, 32'(det_pulse), 32'(exp_pulse));
            if (c == 8) chk("s4_ch_after_rst", c, 32'(det_ch), 32'(2'd0));
            rst_n   = (c != 7);
            tone_in = 4'b0010;
            step();
        end

        // 5a: enable dropped during qualification
        reset_dut();
        for (int c = 0; c < 13; c++) begin
            chk("s5a_dir",   c, 32'(td_dir),    32'(c_STOP));
            chk("s5a_pulse", c, 32'(det_pulse), 32'(1'b0));
            en      = (c < 3);
            tone_in = 4'b0001;
            step();
        end

        // 5b: enable dropped during hold, code still held the full window
        reset_dut();
        for (int c = 0; c < 14; c++) begin
            exp_dir   = (c >= 5 && c <= 10) ? 3'b010 : c_STOP;
            exp_pulse = (c == 5);
            chk("s5b_dir",   c, 32'(td_dir),    32'(exp_dir));
            chk("s5b_pulse", c, 32'(det_pulse), 32'(exp_pulse));
            en      = !(c >= 6);
            tone_in = (c <= 4) ? 4'b0100 : 4'b0000;
            step();
        end

        // 6: no re-arm lockout, channel 3 held 30 cycles repeats every 11
        reset_dut();
        for (int c = 0; c < 34; c++) begin
            exp_dir   = (c >= 5 && ((c - 5) % 11) < 6) ? 3'b011 : c_STOP;
            exp_pulse = (c >= 5 && ((c - 5) % 11) == 0);
            chk("s6_dir",   c, 32'(td_dir_nr),    32'(exp_dir));
            chk("s6_pulse", c, 32'(det_pulse_nr), 32'(exp_pulse));
            if (c >= 5) chk("s6_ch", c, 32'(det_ch_nr), 32'(2'd3));
            tone_in = (c < 30) ? 4'b1000 : 4'b0000;
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
